// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcode and funct
// constants, ALUControl codes, FSM state encodings, the bundled control word
// produced by the output decoder, and the instruction legality check.
package multicycle_control_unit_pkg;

   localparam int unsigned STATE_W_DEF = 4;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_INP   = 6'b011111;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type funct codes (IR[5:0])
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_op_e;

   // Encoding 4'd15 is unused and recovers to FETCH.
   typedef enum logic [STATE_W_DEF-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_ADDIEX = 4'd8,
      S_ORIEX  = 4'd9,
      S_INPEX  = 4'd10,
      S_IMMWB  = 4'd11,
      S_BRANCH = 4'd12,
      S_JUMP   = 4'd13,
      S_ERROR  = 4'd14
   } state_e;

   typedef struct packed {
      logic       PCen;
      logic       IorD;
      logic       MemWrite;
      logic       IRWrite;
      logic       RegDst;
      logic       MemtoReg;
      logic       RegWrite;
      logic       ALUSrcA;
      logic [1:0] ALUSrcB;
      logic [2:0] ALUControl;
      logic       PCsrc;
      logic       Jump;
      logic       Ori;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

   function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] funct);
      case (op)
         OP_RTYPE: return funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_INP, OP_J: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic alu_op_e funct_alu(input logic [5:0] funct);
      case (funct)
         F_SUB:   return ALU_SUB;
         F_AND:   return ALU_AND;
         F_OR:    return ALU_OR;
         F_SLT:   return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control unit and the datapath.
//   op, Funct, zero_i : instruction fields and ALU zero flag (datapath -> control)
//   PCen .. illegal_o : every datapath control input plus status pulses (control -> datapath)
// master: the control unit; slave: the datapath (or a bench standing in for it).
interface multicycle_control_unit_if;
   logic [5:0] op;
   logic [5:0] Funct;
   logic       zero_i;
   logic       PCen;
   logic       IorD;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic       PCsrc;
   logic       Jump;
   logic       Ori;
   logic       instr_done_o;
   logic       illegal_o;

   modport master (
      input  op, Funct, zero_i,
      output PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, ALUControl, PCsrc, Jump, Ori,
             instr_done_o, illegal_o
   );

   modport slave (
      output op, Funct, zero_i,
      input  PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, ALUControl, PCsrc, Jump, Ori,
             instr_done_o, illegal_o
   );
endinterface

// File: rtl/multicycle_control_unit_ctrl_output_decode.sv
// Combinational output decoder: {state, op, Funct, zero_i} -> control word.
// Ports:
//   state_i : current FSM state
//   op_i    : opcode, used only to flag illegal instructions in DECODE
//   funct_i : R-type funct, selects ALUControl in EXEC
//   zero_i  : ALU zero flag, gates the branch PC enable (the one Mealy term)
//   ctrl_o  : all datapath controls plus instr_done / illegal pulses
module ctrl_output_decode
   import multicycle_control_unit_pkg::*;
(
   input  state_e     state_i,
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   input  logic       zero_i,
   output ctrl_t      ctrl_o
);

   logic pc_write;
   logic branch;

   always_comb begin
      ctrl_o   = '0;
      pc_write = 1'b0;
      branch   = 1'b0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.IRWrite    = 1'b1;
            ctrl_o.ALUSrcB    = 2'b01;
            ctrl_o.ALUControl = ALU_ADD;
            pc_write          = 1'b1;
         end
         S_DECODE: begin
            ctrl_o.ALUSrcB    = 2'b11;
            ctrl_o.ALUControl = ALU_ADD;
            ctrl_o.illegal    = ~instr_legal(op_i, funct_i);
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl_o.ALUSrcA    = 1'b1;
            ctrl_o.ALUSrcB    = 2'b10;
            ctrl_o.ALUControl = ALU_ADD;
         end
         S_MEMRD: ctrl_o.IorD = 1'b1;
         S_MEMWB: begin
            ctrl_o.MemtoReg   = 1'b1;
            ctrl_o.RegWrite   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.IorD       = 1'b1;
            ctrl_o.MemWrite   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_EXEC: begin
            ctrl_o.ALUSrcA    = 1'b1;
            ctrl_o.ALUControl = funct_alu(funct_i);
         end
         S_ALUWB: begin
            ctrl_o.RegDst     = 1'b1;
            ctrl_o.RegWrite   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_ORIEX, S_INPEX: begin
            ctrl_o.ALUSrcA    = 1'b1;
            ctrl_o.ALUSrcB    = 2'b10;
            ctrl_o.ALUControl = ALU_OR;
            ctrl_o.Ori        = (state_i == S_INPEX);
         end
         S_IMMWB: begin
            ctrl_o.RegWrite   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.ALUSrcA    = 1'b1;
            ctrl_o.ALUControl = ALU_SUB;
            ctrl_o.PCsrc      = 1'b1;
            ctrl_o.instr_done = 1'b1;
            branch            = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.Jump       = 1'b1;
            ctrl_o.instr_done = 1'b1;
            pc_write          = 1'b1;
         end
         default: ;
      endcase
      ctrl_o.PCen = pc_write | (branch & zero_i);
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle MIPS core.
// Ports:
//   clk   : core clock, state updates on the rising edge
//   reset : synchronous active-high; next state FETCH, all outputs held at 0
//   bus   : control bundle (op/Funct/zero_i in, all datapath controls out)
// Parameters:
//   STATE_W      : state register width
//   ILLEGAL_TRAP : 0 = illegal instruction returns to FETCH as a NOP,
//                  1 = park in ERROR until reset
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int unsigned STATE_W      = STATE_W_DEF,
   parameter bit          ILLEGAL_TRAP = 1'b0
) (
   input  logic                        clk,
   input  logic                        reset,
   multicycle_control_unit_if.master   bus
);

   logic [STATE_W-1:0] state_q;
   state_e             state_cur;
   state_e             state_d;
   ctrl_t              ctrl_dec;
   ctrl_t              ctrl;

   assign state_cur = state_e'(state_q);

   always_comb begin
      state_d = S_FETCH;
      case (state_cur)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            if (!instr_legal(bus.op, bus.Funct)) begin
               state_d = ILLEGAL_TRAP ? S_ERROR : S_FETCH;
            end else begin
               case (bus.op)
                  OP_LW, OP_SW: state_d = S_MEMADR;
                  OP_RTYPE:     state_d = S_EXEC;
                  OP_BEQ:       state_d = S_BRANCH;
                  OP_ADDI:      state_d = S_ADDIEX;
                  OP_ORI:       state_d = S_ORIEX;
                  OP_INP:       state_d = S_INPEX;
                  OP_J:         state_d = S_JUMP;
                  default:      state_d = S_FETCH;
               endcase
            end
         end
         S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX, S_ORIEX, S_INPEX: state_d = S_IMMWB;
         S_ERROR:  state_d = S_ERROR;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= STATE_W'(S_FETCH);
      end else begin
         state_q <= STATE_W'(state_d);
      end
   end

   ctrl_output_decode u_decode (
      .state_i (state_cur),
      .op_i    (bus.op),
      .funct_i (bus.Funct),
      .zero_i  (bus.zero_i),
      .ctrl_o  (ctrl_dec)
   );

   // Masking with reset keeps every write strobe low in any cycle where reset
   // is high, so an abandoned instruction cannot write on the reset edge.
   assign ctrl = reset ? '0 : ctrl_dec;

   assign bus.PCen         = ctrl.PCen;
   assign bus.IorD         = ctrl.IorD;
   assign bus.MemWrite     = ctrl.MemWrite;
   assign bus.IRWrite      = ctrl.IRWrite;
   assign bus.RegDst       = ctrl.RegDst;
   assign bus.MemtoReg     = ctrl.MemtoReg;
   assign bus.RegWrite     = ctrl.RegWrite;
   assign bus.ALUSrcA      = ctrl.ALUSrcA;
   assign bus.ALUSrcB      = ctrl.ALUSrcB;
   assign bus.ALUControl   = ctrl.ALUControl;
   assign bus.PCsrc        = ctrl.PCsrc;
   assign bus.Jump         = ctrl.Jump;
   assign bus.Ori          = ctrl.Ori;
   assign bus.instr_done_o = ctrl.instr_done;
   assign bus.illegal_o    = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: stimulus pushes the expected control word for each cycle,
// a negedge monitor pops and compares. dut0 has ILLEGAL_TRAP=0, dut1 has 1.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic       PCen;
      logic       IorD;
      logic       MemWrite;
      logic       IRWrite;
      logic       RegDst;
      logic       MemtoReg;
      logic       RegWrite;
      logic       ALUSrcA;
      logic [1:0] ALUSrcB;
      logic [2:0] ALUControl;
      logic       PCsrc;
      logic       Jump;
      logic       Ori;
      logic       done;
      logic       illegal;
   } ctl_t;

   typedef struct {
      ctl_t       e;
      logic [5:0] op;
      int         step;
   } item_t;

   logic clk;
   logic rst0, rst1;
   int   checks = 0;
   int   errors = 0;
   bit   done1 = 1'b0;
   item_t q0[$];
   item_t q1[$];
   ctl_t  act0, act1;

   multicycle_control_unit_if bus0();
   multicycle_control_unit_if bus1();

   multicycle_control_unit #(.STATE_W(4), .ILLEGAL_TRAP(1'b0)) dut0 (
      .clk(clk), .reset(rst0), .bus(bus0));
   multicycle_control_unit #(.STATE_W(4), .ILLEGAL_TRAP(1'b1)) dut1 (
      .clk(clk), .reset(rst1), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign act0 = {bus0.PCen, bus0.IorD, bus0.MemWrite, bus0.IRWrite, bus0.RegDst,
                  bus0.MemtoReg, bus0.RegWrite, bus0.ALUSrcA, bus0.ALUSrcB,
                  bus0.ALUControl, bus0.PCsrc, bus0.Jump, bus0.Ori,
                  bus0.instr_done_o, bus0.illegal_o};
   assign act1 = {bus1.PCen, bus1.IorD, bus1.MemWrite, bus1.IRWrite, bus1.RegDst,
                  bus1.MemtoReg, bus1.RegWrite, bus1.ALUSrcA, bus1.ALUSrcB,
                  bus1.ALUControl, bus1.PCsrc, bus1.Jump, bus1.Ori,
                  bus1.instr_done_o, bus1.illegal_o};

   // Reference model: which instructions exist, and what each cycle of each one does.
   function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'b000000)
         return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      return op inside {6'b100011, 6'b101011, 6'b000100, 6'b001000,
                        6'b001101, 6'b011111, 6'b000010};
   endfunction

   function automatic logic [2:0] r_alu(input logic [5:0] fn);
      case (fn)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Expected outputs for cycle s (0 = FETCH) of instruction op/fn, with zero flag z.
   // Returns 0 once the instruction has no cycle s.
   function automatic bit plan(input logic [5:0] op, input logic [5:0] fn,
                               input int s, input logic z, output ctl_t e);
      e = '0;
      if (s == 0) begin
         e.IRWrite = 1'b1; e.ALUSrcB = 2'b01; e.ALUControl = 3'b010; e.PCen = 1'b1;
         return 1'b1;
      end
      if (s == 1) begin
         e.ALUSrcB = 2'b11; e.ALUControl = 3'b010; e.illegal = !legal(op, fn);
         return 1'b1;
      end
      if (!legal(op, fn)) return 1'b0;
      case (op)
         6'b100011, 6'b101011: begin
            if (s == 2) begin
               e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10; e.ALUControl = 3'b010;
            end else if (op == 6'b100011 && s == 3) begin
               e.IorD = 1'b1;
            end else if (op == 6'b100011 && s == 4) begin
               e.MemtoReg = 1'b1; e.RegWrite = 1'b1; e.done = 1'b1;
            end else if (op == 6'b101011 && s == 3) begin
               e.IorD = 1'b1; e.MemWrite = 1'b1; e.done = 1'b1;
            end else return 1'b0;
         end
         6'b000000: begin
            if (s == 2) begin
               e.ALUSrcA = 1'b1; e.ALUControl = r_alu(fn);
            end else if (s == 3) begin
               e.RegDst = 1'b1; e.RegWrite = 1'b1; e.done = 1'b1;
            end else return 1'b0;
         end
         6'b001000, 6'b001101, 6'b011111: begin
            if (s == 2) begin
               e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10;
               e.ALUControl = (op == 6'b001000) ? 3'b010 : 3'b001;
               e.Ori = (op == 6'b011111);
            end else if (s == 3) begin
               e.RegWrite = 1'b1; e.done = 1'b1;
            end else return 1'b0;
         end
         6'b000100: begin
            if (s != 2) return 1'b0;
            e.ALUSrcA = 1'b1; e.ALUControl = 3'b110; e.PCsrc = 1'b1;
            e.PCen = z; e.done = 1'b1;
         end
         default: begin
            if (s != 2) return 1'b0;
            e.Jump = 1'b1; e.PCen = 1'b1; e.done = 1'b1;
         end
      endcase
      return 1'b1;
   endfunction

   task automatic drive(input int d, input logic [5:0] op, input logic [5:0] fn, input logic z);
      if (d == 0) begin bus0.op = op; bus0.Funct = fn; bus0.zero_i = z; end
      else        begin bus1.op = op; bus1.Funct = fn; bus1.zero_i = z; end
   endtask

   task automatic set_rst(input int d, input logic v);
      if (d == 0) rst0 = v; else rst1 = v;
   endtask

   task automatic push(input int d, input ctl_t e, input logic [5:0] op, input int s);
      item_t it;
      it.e = e; it.op = op; it.step = s;
      if (d == 0) q0.push_back(it); else q1.push_back(it);
   endtask

   // One cycle with reset high: all outputs expected at 0.
   task automatic reset_cycle(input int d);
      logic [5:0] op;
      op = 6'($urandom);
      drive(d, op, 6'($urandom), 1'($urandom_range(0, 1)));
      set_rst(d, 1'b1);
      push(d, '0, op, 99);
      @(posedge clk); #1;
      set_rst(d, 1'b0);
   endtask

   // zmode: 0/1 fixed zero flag, 2 random. abort_at: cycle index where reset hits, -1 none.
   task automatic run(input int d, input logic [5:0] op, input logic [5:0] fn,
                      input int zmode, input int abort_at);
      ctl_t e;
      logic z;
      for (int s = 0; s < 8; s++) begin
         z = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
         if (!plan(op, fn, s, z, e)) break;
         drive(d, op, fn, z);
         if (s == abort_at) begin
            reset_cycle(d);
            break;
         end
         push(d, e, op, s);
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [5:0] pick_op(input int k);
      case (k)
         0: return 6'b100011;
         1: return 6'b101011;
         2: return 6'b000000;
         3: return 6'b000100;
         4: return 6'b001000;
         5: return 6'b001101;
         6: return 6'b011111;
         7: return 6'b000010;
         default: return 6'($urandom);
      endcase
   endfunction

   function automatic logic [5:0] pick_fn(input int k);
      case (k)
         0: return 6'b100000;
         1: return 6'b100010;
         2: return 6'b100100;
         3: return 6'b100101;
         4: return 6'b101010;
         default: return 6'($urandom);
      endcase
   endfunction

   always @(negedge clk) begin
      if (q0.size() > 0) begin
         item_t it;
         it = q0.pop_front();
         checks++;
         if (act0 !== it.e) begin
            errors++;
            $display("FAIL dut0 op=%b step=%0d actual=%h expected=%h", it.op, it.step, act0, it.e);
         end
      end
      if (q1.size() > 0) begin
         item_t it;
         it = q1.pop_front();
         checks++;
         if (act1 !== it.e) begin
            errors++;
            $display("FAIL dut1 op=%b step=%0d actual=%h expected=%h", it.op, it.step, act1, it.e);
         end
      end
   end

   // ILLEGAL_TRAP=0 instance: directed cases then random instruction stream.
   initial begin
      rst0 = 1'b1;
      drive(0, '0, '0, 1'b0);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) reset_cycle(0);
      run(0, 6'b000000, 6'b100000, 2, -1);   // R add
      run(0, 6'b100011, 6'b000000, 2, -1);   // LW
      run(0, 6'b101011, 6'b000000, 2, -1);   // SW
      run(0, 6'b000100, 6'b000000, 1, -1);   // BEQ taken
      run(0, 6'b000100, 6'b000000, 0, -1);   // BEQ not taken
      run(0, 6'b000010, 6'b000000, 2, -1);   // J
      run(0, 6'b011111, 6'b000000, 2, -1);   // INP
      run(0, 6'b001101, 6'b000000, 2, -1);   // ORI
      run(0, 6'b111110, 6'b000000, 2, -1);   // illegal op
      run(0, 6'b000000, 6'b111111, 2, -1);   // illegal funct
      run(0, 6'b101011, 6'b000000, 2, 3);    // reset during MEMWR
      run(0, 6'b001000, 6'b000000, 2, -1);   // ADDI after abort
      for (int n = 0; n < 300; n++) begin
         logic [5:0] op, fn;
         int ab;
         op = pick_op(int'($urandom_range(0, 9)));
         fn = pick_fn(int'($urandom_range(0, 6)));
         ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
         run(0, op, fn, 2, ab);
      end
      wait (done1);
      @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // ILLEGAL_TRAP=1 instance: illegal op parks in ERROR until reset.
   initial begin
      rst1 = 1'b1;
      drive(1, '0, '0, 1'b0);
      @(posedge clk); #1;
      reset_cycle(1);
      run(1, 6'b111110, 6'b100000, 2, -1);
      for (int i = 0; i < 6; i++) begin
         logic [5:0] op;
         op = pick_op(int'($urandom_range(0, 8)));
         drive(1, op, 6'b100000, 1'($urandom_range(0, 1)));
         push(1, '0, op, 50 + i);
         @(posedge clk); #1;
      end
      reset_cycle(1);
      run(1, 6'b001000, 6'b000000, 2, -1);
      run(1, 6'b000000, 6'b101010, 2, -1);
      done1 = 1'b1;
   end

endmodule
